receive: RTL and testbench

UART receiver, the receive-side counterpart of the team's `transmit` block. It oversamples a serial `rxd` line and recovers 8N1 frames: one start bit (0), 8 data bits LSB first, and one or more stop bits (1). Each received byte is presented on a valid/ready output port. The block sits between the board's RX pin and the controller's byte consumer, gated by the same `connection_status` enable as the transmitter.

---
 rtl/receive.sv | 150 +++++++++++++++
 tb/tb_receive.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/receive.sv
// UART 8N1 receiver with 2-flop input sync and valid/ready byte port.
// Ports: clk, rst (sync, active-high), connection_status (enable), rxd;
// word/word_valid/word_ready byte port; receive_busy, frame_error, overrun.
module receive #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       connection_status,
  input  logic       rxd,
  output logic [7:0] word,
  output logic       word_valid,
  input  logic       word_ready,
  output logic       receive_busy,
  output logic       frame_error,
  output logic       overrun
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int PW   = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [PW-1:0] HALF_P = PW'(HALF);
  localparam logic [PW-1:0] LAST_P = PW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  logic          rxd_m;
  logic          rxd_s;
  state_t        state;
  state_t        state_n;
  logic [PW-1:0] phase;
  logic [PW-1:0] phase_n;
  logic [3:0]    bit_cnt;
  logic [3:0]    bit_n;
  logic [7:0]    sh;
  logic [7:0]    sh_n;
  logic          samp;
  logic          good;
  logic          bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // Counters hold the position of the current cycle relative to T0,
  // so a sample point is simply phase == HALF.
  always_comb begin
    samp    = (phase == HALF_P);
    state_n = state;
    sh_n    = sh;
    good    = 1'b0;
    bad     = 1'b0;
    if (phase == LAST_P) begin
      phase_n = '0;
      bit_n   = bit_cnt + 4'd1;
    end else begin
      phase_n = phase + PW'(1);
      bit_n   = bit_cnt;
    end
    unique case (state)
      IDLE: begin
        phase_n = '0;
        bit_n   = '0;
        // T0 is itself the start sample when HALF is 0
        if (!rxd_s) begin
          state_n = START;
          if (CLKS_PER_BIT == 1) bit_n = 4'd1;
          else phase_n = PW'(1);
        end
      end
      START, DATA: begin
        if (samp) begin
          if (bit_cnt == 4'd0) begin
            state_n = rxd_s ? IDLE : DATA;
          end else begin
            sh_n    = {rxd_s, sh[7:1]};
            state_n = (bit_cnt == 4'd8) ? STOP : DATA;
          end
        end
      end
      STOP: begin
        if (samp) begin
          if (rxd_s) begin
            good    = 1'b1;
            state_n = IDLE;
          end else begin
            bad     = 1'b1;
            state_n = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rxd_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE || state_n == WAIT_HIGH) begin
      phase_n = '0;
      bit_n   = '0;
    end
    if (!connection_status) begin
      state_n = IDLE;
      phase_n = '0;
      bit_n   = '0;
      sh_n    = '0;
      good    = 1'b0;
      bad     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= '0;
      bit_cnt     <= '0;
      sh          <= '0;
      word        <= '0;
      word_valid  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      bit_cnt     <= bit_n;
      sh          <= sh_n;
      frame_error <= bad;
      overrun     <= good && word_valid && !word_ready;
      if (good && (!word_valid || word_ready)) begin
        word       <= sh;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

  assign receive_busy = (state != IDLE);

endmodule

// File: tb/tb_receive.sv
// Scoreboard bench for receive: three instances (1, 4, 16 clocks/bit).
// Stimulus pushes expected bytes; a forked monitor pops on handshakes.
module tb_receive;

  logic       clk = 1'b0;
  logic [2:0] rst_v;
  logic [2:0] conn_v;
  logic [2:0] rxd_v;
  logic [2:0] rdy_v;
  logic [7:0] wd0, wd1, wd2;
  logic [2:0] vld, busy, fe, ov;
  int         cyc = 0;

  int tests = 0;
  int fails = 0;
  int fe_cnt [3];
  int ov_cnt [3];
  int vfirst0;
  int vhigh0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  receive #(.CLKS_PER_BIT(1)) u0 (
    .clk(clk), .rst(rst_v[0]),
    .connection_status(conn_v[0]), .rxd(rxd_v[0]),
    .word(wd0), .word_valid(vld[0]), .word_ready(rdy_v[0]),
    .receive_busy(busy[0]), .frame_error(fe[0]),
    .overrun(ov[0]));

  receive #(.CLKS_PER_BIT(4)) u1 (
    .clk(clk), .rst(rst_v[1]),
    .connection_status(conn_v[1]), .rxd(rxd_v[1]),
    .word(wd1), .word_valid(vld[1]), .word_ready(rdy_v[1]),
    .receive_busy(busy[1]), .frame_error(fe[1]),
    .overrun(ov[1]));

  receive #(.CLKS_PER_BIT(16)) u2 (
    .clk(clk), .rst(rst_v[2]),
    .connection_status(conn_v[2]), .rxd(rxd_v[2]),
    .word(wd2), .word_valid(vld[2]), .word_ready(rdy_v[2]),
    .receive_busy(busy[2]), .frame_error(fe[2]),
    .overrun(ov[2]));

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic sb_pop(int d, logic [7:0] act);
    logic [7:0] e;
    int         n;
    n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    if (n == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_word_d%0d: got %0h want none", d, act);
    end else begin
      if (d == 0) e = q0.pop_front();
      else if (d == 1) e = q1.pop_front();
      else e = q2.pop_front();
      check($sformatf("word_d%0d", d), {24'd0, act}, {24'd0, e});
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_v[0] && vld[0] && rdy_v[0]) sb_pop(0, wd0);
      if (!rst_v[1] && vld[1] && rdy_v[1]) sb_pop(1, wd1);
      if (!rst_v[2] && vld[2] && rdy_v[2]) sb_pop(2, wd2);
      if (vld[0]) begin
        vhigh0++;
        if (vfirst0 < 0) vfirst0 = cyc;
      end
      for (int d = 0; d < 3; d++) begin
        if (fe[d]) fe_cnt[d]++;
        if (ov[d]) ov_cnt[d]++;
        if (fe[d] && ov[d]) begin
          tests++;
          fails++;
          $display("FAIL fe_ov_excl_d%0d: got both want one", d);
        end
      end
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int cpb(int d);
    return (d == 0) ? 1 : (d == 1) ? 4 : 16;
  endfunction

  task automatic send_part(int d, logic [7:0] b, int nb);
    int c = cpb(d);
    rxd_v[d] = 1'b0;
    tick(c);
    for (int i = 0; i < nb; i++) begin
      rxd_v[d] = b[i];
      tick(c);
    end
  endtask

  task automatic send(int d, logic [7:0] b, logic stp);
    send_part(d, b, 8);
    rxd_v[d] = stp;
    tick(cpb(d));
  endtask

  task automatic idle(int d, int n);
    rxd_v[d] = 1'b1;
    tick(n);
  endtask

  initial begin
    int s;
    rst_v   = 3'b111;
    conn_v  = 3'b111;
    rxd_v   = 3'b111;
    rdy_v   = 3'b111;
    vfirst0 = 0;
    vhigh0  = 0;
    for (int d = 0; d < 3; d++) begin
      fe_cnt[d] = 0;
      ov_cnt[d] = 0;
    end
    fork
      monitor();
    join_none
    tick(3);
    check("rst_word", {24'd0, wd0}, 32'h00);
    check("rst_valid", {31'd0, vld[0]}, 32'd0);
    check("rst_busy", {31'd0, busy[0]}, 32'd0);
    check("rst_fe", {31'd0, fe[0]}, 32'd0);
    check("rst_ov", {31'd0, ov[0]}, 32'd0);
    rst_v = 3'b000;
    tick(2);

    // A5 at one clock per bit: visible T0+10, T0 = drive + 2
    vfirst0 = -1;
    vhigh0  = 0;
    q0.push_back(8'hA5);
    s = cyc;
    send(0, 8'hA5, 1'b1);
    idle(0, 13);
    check("a5_latency", vfirst0 - s, 32'd12);
    check("a5_valid_width", vhigh0, 32'd1);

    // false start at 16 clocks per bit
    s = cyc;
    rxd_v[2] = 1'b0;
    tick(5);
    rxd_v[2] = 1'b1;
    check("fs_busy_hi", {31'd0, busy[2]}, 32'd1);
    tick(6);
    check("fs_busy_lo", {31'd0, busy[2]}, 32'd0);
    tick(20);
    check("fs_no_fe", fe_cnt[2], 32'd0);
    check("fs_no_word", q2.size(), 32'd0);

    // framing error, held break, then good frame
    send(1, 8'h3C, 1'b0);
    rxd_v[1] = 1'b0;
    tick(20);
    check("fe_count", fe_cnt[1], 32'd1);
    check("fe_wait_busy", {31'd0, busy[1]}, 32'd1);
    idle(1, 8);
    check("fe_idle", {31'd0, busy[1]}, 32'd0);
    q1.push_back(8'h81);
    send(1, 8'h81, 1'b1);
    idle(1, 8);
    check("fe_count_after", fe_cnt[1], 32'd1);

    // overrun with consumer stalled
    rdy_v[0] = 1'b0;
    q0.push_back(8'h11);
    send(0, 8'h11, 1'b1);
    idle(0, 13);
    send(0, 8'h22, 1'b1);
    idle(0, 13);
    check("ovr_word", {24'd0, wd0}, 32'h11);
    check("ovr_valid", {31'd0, vld[0]}, 32'd1);
    check("ovr_count", ov_cnt[0], 32'd1);
    rdy_v[0] = 1'b1;
    tick(1);
    rdy_v[0] = 1'b0;
    tick(1);
    check("ovr_valid_drop", {31'd0, vld[0]}, 32'd0);
    check("ovr_word_hold", {24'd0, wd0}, 32'h11);
    rdy_v[0] = 1'b1;

    // enable dropped mid-frame
    send_part(1, 8'h5A, 4);
    rxd_v[1] = 1'b1;
    tick(2);
    conn_v[1] = 1'b0;
    tick(1);
    check("conn_busy", {31'd0, busy[1]}, 32'd0);
    check("conn_valid", {31'd0, vld[1]}, 32'd0);
    idle(1, 4);
    conn_v[1] = 1'b1;
    tick(2);
    q1.push_back(8'h5A);
    send(1, 8'h5A, 1'b1);
    idle(1, 8);
    check("conn_word_kept", {24'd0, wd1}, 32'h5A);

    // reset mid-frame
    send_part(1, 8'hC3, 4);
    tick(2);
    rst_v[1] = 1'b1;
    tick(1);
    check("rstab_word", {24'd0, wd1}, 32'h00);
    check("rstab_valid", {31'd0, vld[1]}, 32'd0);
    check("rstab_busy", {31'd0, busy[1]}, 32'd0);
    check("rstab_flags", {30'd0, fe[1], ov[1]}, 32'd0);
    rst_v[1] = 1'b0;
    idle(1, 4);
    q1.push_back(8'h5A);
    send(1, 8'h5A, 1'b1);
    idle(1, 8);

    // back-to-back frames with a 13-cycle stop gap
    q0.push_back(8'h00);
    q0.push_back(8'hFF);
    q0.push_back(8'h5A);
    send(0, 8'h00, 1'b1);
    idle(0, 12);
    send(0, 8'hFF, 1'b1);
    idle(0, 12);
    send(0, 8'h5A, 1'b1);
    idle(0, 20);
    check("lb_fe", fe_cnt[0], 32'd0);
    check("lb_ov", ov_cnt[0], 32'd1);
    check("lb_fe_d1", fe_cnt[1], 32'd1);

    tick(10);
    check("q0_empty", q0.size(), 32'd0);
    check("q1_empty", q1.size(), 32'd0);
    check("q2_empty", q2.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
